// File: rtl/i2c_slave_core_if.sv
// Local-side bundle of the I2C target: bus clock in, TX byte/handshake, RX byte out.
// SDA stays a plain inout on the core so the open-drain net resolves at the pins.
interface i2c_slave_core_if;
    logic       SCL;
    logic [7:0] D;
    logic       D_ready;
    logic [7:0] Q;

    modport master (output SCL, output D, input D_ready, input Q);
    modport slave  (input SCL, input D, output D_ready, output Q);
endinterface

// File: rtl/i2c_slave_core.sv
// I2C target: synchronizes SCL/SDA, decodes START/STOP + 7-bit address, receives write bytes
// into Q and shifts D out on reads; bus events lag the pins by SYNC_STAGES+1 CLK.
module i2c_slave_core #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            ENB,
    inout  wire             SDA,
    i2c_slave_core_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl_s, sda_s, scl_d, sda_d;
    logic       scl_rise, scl_fall, start_evt, stop_evt;
    logic [3:0] cnt;
    logic [7:0] rx_sh, tx_sh, q_reg;
    logic       ack_seen, d_ready_reg;
    logic       sda_oe, load_tx;

    // Synchronizer chain is left unreset so it always mirrors the live bus and
    // a reset release cannot fabricate a START/STOP edge.
    always_ff @(posedge CLK) begin
        scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.SCL};
        sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
        scl_d    <= scl_s;
        sda_d    <= sda_s;
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_evt = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_evt  = scl_s & scl_d & ~sda_d & sda_s;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!ENB || stop_evt) begin
            state_nxt = IDLE;
        end else if (start_evt) begin
            state_nxt = ADDR;
        end else begin
            case (state)
                ADDR:     if (scl_fall && cnt == 4'd8)
                              state_nxt = (rx_sh[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_fall) state_nxt = rx_sh[0] ? RD_DATA : WR_DATA;
                WR_DATA:  if (scl_fall && cnt == 4'd8) state_nxt = WR_ACK;
                WR_ACK:   if (scl_fall) state_nxt = WR_DATA;
                RD_DATA:  if (scl_fall && cnt == 4'd8) state_nxt = RD_ACK;
                RD_ACK:   if (scl_fall) state_nxt = ack_seen ? RD_DATA : IGNORE;
                default:  state_nxt = state;
            endcase
        end
    end

    // SDA only ever pulled low; a TX '1' is the released line.
    always_comb begin
        sda_oe  = 1'b0;
        load_tx = (state_nxt == RD_DATA) && (state != RD_DATA);
        case (state)
            ADDR_ACK, WR_ACK: sda_oe = 1'b1;
            RD_DATA:          sda_oe = ~tx_sh[7];
            default:          sda_oe = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt         <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            q_reg       <= '0;
            ack_seen    <= 1'b0;
            d_ready_reg <= 1'b0;
        end else begin
            d_ready_reg <= 1'b0;
            if (start_evt || state_nxt != state) begin
                cnt <= '0;
            end else if (scl_rise && (state == ADDR || state == WR_DATA || state == RD_DATA)) begin
                cnt <= cnt + 4'd1;
            end
            if (scl_rise && (state == ADDR || state == WR_DATA)) begin
                rx_sh <= {rx_sh[6:0], sda_s};
            end
            if (load_tx) begin
                tx_sh       <= bus.D;
                d_ready_reg <= 1'b1;
            end else if (state == RD_DATA && scl_fall) begin
                tx_sh <= {tx_sh[6:0], 1'b1};
            end
            if (state == WR_DATA && state_nxt == WR_ACK) begin
                q_reg <= rx_sh;
            end
            if (state == RD_ACK && scl_rise) begin
                ack_seen <= ~sda_s;
            end
        end
    end

    assign SDA         = sda_oe ? 1'b0 : 1'bz;
    assign bus.Q       = q_reg;
    assign bus.D_ready = d_ready_reg;
endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: pin-level I2C master, table of write vectors, hand sequences,
// and randomized transactions checked against a transaction-level model.
module tb_i2c_slave_core;
    localparam int QT = 5;
    localparam logic [6:0] MY_ADDR = 7'h50;

    logic clk = 1'b0;
    logic rst;
    logic enb;
    logic m_low;
    wire  sda;

    i2c_slave_core_if bus();

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_slave_core #(.SLAVE_ADDR(MY_ADDR), .SYNC_STAGES(2)) dut (
        .CLK(clk), .RESET(rst), .ENB(enb), .SDA(sda), .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int slave_low_tot = 0;
    int dready_tot = 0;
    int dready_consec = 0;
    logic dready_prev = 1'b0;

    // Sampled mid-way between edges: bench drives on negedge, DUT updates on posedge.
    always begin
        @(posedge clk);
        #3;
        if (!m_low && sda == 1'b0) slave_low_tot++;
        if (bus.D_ready) dready_tot++;
        if (bus.D_ready && dready_prev) dready_consec++;
        dready_prev = bus.D_ready;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic qwait();
        repeat (QT) @(negedge clk);
    endtask

    task automatic xfer_bit(input logic b, output logic s);
        qwait(); m_low = ~b;
        qwait(); bus.SCL = 1'b1;
        qwait(); s = sda;
        qwait(); bus.SCL = 1'b0;
    endtask

    task automatic i2c_start();
        if (bus.SCL == 1'b0) begin
            qwait(); m_low = 1'b0;
            qwait(); bus.SCL = 1'b1;
        end
        qwait(); m_low = 1'b1;
        qwait(); bus.SCL = 1'b0;
    endtask

    task automatic i2c_stop();
        qwait(); m_low = 1'b1;
        qwait(); bus.SCL = 1'b1;
        qwait(); m_low = 1'b0;
        qwait(); qwait();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], s);
        xfer_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, input logic [7:0] next_d, output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, s);
            v[i] = s;
        end
        bus.D = next_d;
        xfer_bit(~mack, s);
    endtask

    typedef struct {
        logic       enb;
        logic [6:0] addr;
        logic [7:0] data;
        logic       exp_ack;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic       ack;
        logic [7:0] v;
        int         low0, dr0;

        vecs[0] = '{1'b1, 7'h50, 8'hA5, 1'b1, 8'hA5};
        vecs[1] = '{1'b1, 7'h51, 8'h3C, 1'b0, 8'hA5};
        vecs[2] = '{1'b1, 7'h50, 8'h00, 1'b1, 8'h00};
        vecs[3] = '{1'b1, 7'h50, 8'hFF, 1'b1, 8'hFF};
        vecs[4] = '{1'b1, 7'h28, 8'h12, 1'b0, 8'hFF};
        vecs[5] = '{1'b0, 7'h50, 8'h77, 1'b0, 8'hFF};
        vecs[6] = '{1'b1, 7'h50, 8'h5A, 1'b1, 8'h5A};

        rst = 1'b1; enb = 1'b1; m_low = 1'b0; bus.SCL = 1'b1; bus.D = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_q", {24'd0, bus.Q}, 32'h00);
        check("reset_dready", {31'd0, bus.D_ready}, 32'd0);
        check("reset_sda_released", {31'd0, sda}, 32'd1);
        repeat (4) @(negedge clk);

        // Table of single-byte writes
        for (int i = 0; i < 7; i++) begin
            enb = vecs[i].enb;
            qwait();
            low0 = slave_low_tot;
            i2c_start();
            write_byte({vecs[i].addr, 1'b0}, ack);
            check($sformatf("vec%0d_addr_ack", i), {31'd0, ack}, {31'd0, vecs[i].exp_ack});
            write_byte(vecs[i].data, ack);
            check($sformatf("vec%0d_data_ack", i), {31'd0, ack}, {31'd0, vecs[i].exp_ack});
            i2c_stop();
            check($sformatf("vec%0d_q", i), {24'd0, bus.Q}, {24'd0, vecs[i].exp_q});
            if (!vecs[i].exp_ack)
                check($sformatf("vec%0d_no_drive", i), slave_low_tot - low0, 0);
            enb = 1'b1;
        end

        // Read of 0xC3, master NACKs the only byte
        bus.D = 8'hC3;
        dr0 = dready_tot;
        i2c_start();
        write_byte({MY_ADDR, 1'b1}, ack);
        check("rd_addr_ack", {31'd0, ack}, 32'd1);
        read_byte(1'b0, 8'h00, v);
        check("rd_byte", {24'd0, v}, 32'hC3);
        repeat (4) @(negedge clk);
        check("rd_sda_released", {31'd0, sda}, 32'd1);
        check("rd_dready_pulses", dready_tot - dr0, 1);
        i2c_stop();

        // Repeated START between two write transfers
        i2c_start();
        write_byte({MY_ADDR, 1'b0}, ack);
        write_byte(8'h11, ack);
        check("rs_first_ack", {31'd0, ack}, 32'd1);
        check("rs_q_first", {24'd0, bus.Q}, 32'h11);
        i2c_start();
        write_byte({MY_ADDR, 1'b0}, ack);
        check("rs_addr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h22, ack);
        i2c_stop();
        check("rs_q_second", {24'd0, bus.Q}, 32'h22);

        // RESET mid-transfer: rest of the transfer ignored until a fresh START
        i2c_start();
        write_byte({MY_ADDR, 1'b0}, ack);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_q", {24'd0, bus.Q}, 32'h00);
        write_byte(8'h99, ack);
        check("midrst_no_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("midrst_q_kept", {24'd0, bus.Q}, 32'h00);
        i2c_start();
        write_byte({MY_ADDR, 1'b0}, ack);
        write_byte(8'h66, ack);
        i2c_stop();
        check("postrst_q", {24'd0, bus.Q}, 32'h66);

        // Randomized transactions against a transaction-level model
        begin
            logic [7:0] model_q;
            model_q = 8'h66;
            for (int t = 0; t < 24; t++) begin
                logic       r_enb, r_rw, sel;
                logic [6:0] r_addr;
                int         nb;
                logic [7:0] bytes[3];
                r_enb  = ($urandom_range(0, 4) != 0);
                r_addr = ($urandom_range(0, 1) == 1) ? MY_ADDR : 7'($urandom_range(0, 127));
                r_rw   = 1'($urandom_range(0, 1));
                nb     = $urandom_range(1, 3);
                for (int k = 0; k < 3; k++) bytes[k] = 8'($urandom_range(0, 255));
                sel = r_enb && (r_addr == MY_ADDR);

                enb = r_enb;
                qwait();
                low0 = slave_low_tot;
                dr0  = dready_tot;
                bus.D = bytes[0];
                i2c_start();
                write_byte({r_addr, r_rw}, ack);
                check($sformatf("rnd%0d_addr_ack", t), {31'd0, ack}, {31'd0, sel});
                for (int k = 0; k < nb; k++) begin
                    if (r_rw) begin
                        read_byte(k != nb - 1, (k < 2) ? bytes[k + 1] : 8'h00, v);
                        check($sformatf("rnd%0d_rd%0d", t, k), {24'd0, v},
                              {24'd0, sel ? bytes[k] : 8'hFF});
                    end else begin
                        write_byte(bytes[k], ack);
                        check($sformatf("rnd%0d_wack%0d", t, k), {31'd0, ack}, {31'd0, sel});
                        if (sel) model_q = bytes[k];
                    end
                end
                i2c_stop();
                check($sformatf("rnd%0d_q", t), {24'd0, bus.Q}, {24'd0, model_q});
                check($sformatf("rnd%0d_dready", t), dready_tot - dr0, (sel && r_rw) ? nb : 0);
                if (!sel) check($sformatf("rnd%0d_no_drive", t), slave_low_tot - low0, 0);
                enb = 1'b1;
            end
        end

        check("dready_never_consecutive", dready_consec, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
